// File: rtl/ccip_mmio_csr_pkg.sv
// Shared types and constants for the CCI-P MMIO CSR endpoint: the minimal CCI-P
// channel structs it touches, the CSR map, CTRL bit positions and the read-stage record.
package ccip_mmio_csr_pkg;

  typedef enum logic [1:0] {
    MMIO_LEN_4B  = 2'b00,
    MMIO_LEN_8B  = 2'b01,
    MMIO_LEN_64B = 2'b10
  } t_ccip_mmioLen;

  typedef struct packed {
    logic [15:0]   address;
    t_ccip_mmioLen length;
    logic          rsvd;
    logic [8:0]    tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [27:0]  hdr;
    logic [511:0] data;
    logic         rspValid;
    logic         mmioRdValid;
    logic         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  localparam logic [15:0] CSR_DFH_OFS     = 16'h0000;
  localparam logic [15:0] CSR_ID_L_OFS    = 16'h0008;
  localparam logic [15:0] CSR_ID_H_OFS    = 16'h0010;
  localparam logic [15:0] CSR_SCRATCH_OFS = 16'h0020;
  localparam logic [15:0] CSR_CTRL_OFS    = 16'h0028;
  localparam logic [15:0] CSR_STATUS_OFS  = 16'h0030;
  localparam logic [15:0] CSR_RDCNT_OFS   = 16'h0038;
  localparam logic [15:0] CSR_ERR_OFS     = 16'h0040;

  localparam logic [15:0] CSR_DFH_DW     = CSR_DFH_OFS >> 2;
  localparam logic [15:0] CSR_ID_L_DW    = CSR_ID_L_OFS >> 2;
  localparam logic [15:0] CSR_ID_H_DW    = CSR_ID_H_OFS >> 2;
  localparam logic [15:0] CSR_SCRATCH_DW = CSR_SCRATCH_OFS >> 2;
  localparam logic [15:0] CSR_CTRL_DW    = CSR_CTRL_OFS >> 2;
  localparam logic [15:0] CSR_STATUS_DW  = CSR_STATUS_OFS >> 2;
  localparam logic [15:0] CSR_RDCNT_DW   = CSR_RDCNT_OFS >> 2;
  localparam logic [15:0] CSR_ERR_DW     = CSR_ERR_OFS >> 2;

  // QW index = DW address without the DW-within-QW bit
  localparam logic [14:0] CSR_DFH_QW     = CSR_DFH_DW[15:1];
  localparam logic [14:0] CSR_ID_L_QW    = CSR_ID_L_DW[15:1];
  localparam logic [14:0] CSR_ID_H_QW    = CSR_ID_H_DW[15:1];
  localparam logic [14:0] CSR_SCRATCH_QW = CSR_SCRATCH_DW[15:1];
  localparam logic [14:0] CSR_CTRL_QW    = CSR_CTRL_DW[15:1];
  localparam logic [14:0] CSR_STATUS_QW  = CSR_STATUS_DW[15:1];
  localparam logic [14:0] CSR_RDCNT_QW   = CSR_RDCNT_DW[15:1];
  localparam logic [14:0] CSR_ERR_QW     = CSR_ERR_DW[15:1];

  localparam int CTRL_CLR_BIT     = 0;
  localparam int CTRL_ERR_CLR_BIT = 1;

  typedef struct packed {
    logic [8:0]    tid;
    logic [14:0]   qw;
    t_ccip_mmioLen len;
    logic          dw_sel;
  } t_mmio_rd_stage;

endpackage

// File: rtl/ccip_event_counter64.sv
// 64-bit event counter; a clear coinciding with an increment leaves the count at 1.
module ccip_event_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= {63'd0, inc};
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/ccip_mmio_csr_resp.sv
// CCI-P MMIO CSR endpoint: c0 MMIO requests in, c2 read completions out (2-cycle latency).
// Optional ERR capture CSR at 0x40 enabled by defining CCIP_MMIO_CSR_ERR_LOG_EN.
module ccip_mmio_csr_resp
  import ccip_mmio_csr_pkg::*;
#(
  parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000,
  parameter logic [63:0] AFU_ID_L  = 64'h0,
  parameter logic [63:0] AFU_ID_H  = 64'h0
) (
  input  logic           clk,
  input  logic           reset,
  input  t_if_ccip_Rx    cp2af_sRx,
  output t_if_ccip_c2_Tx af2cp_c2Tx,
  output logic [63:0]    ctrl_o,
  output logic           ctrl_clr_pulse_o,
  input  logic [63:0]    status_i
);

`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
  localparam logic [63:0] CTRL_W1_MASK = (64'd1 << CTRL_CLR_BIT) | (64'd1 << CTRL_ERR_CLR_BIT);
`else
  localparam logic [63:0] CTRL_W1_MASK = 64'd1 << CTRL_CLR_BIT;
`endif

  function automatic logic [63:0] merge_wr(input logic [63:0] old, input logic [63:0] wdata,
                                           input t_ccip_mmioLen len, input logic dw_sel);
    if (len == MMIO_LEN_8B) return wdata;
    return dw_sel ? {wdata[31:0], old[31:0]} : {old[63:32], wdata[31:0]};
  endfunction

  function automatic logic [63:0] fmt_rd(input logic [63:0] v, input t_ccip_mmioLen len,
                                         input logic dw_sel);
    logic [31:0] dw;
    dw = dw_sel ? v[63:32] : v[31:0];
    return (len == MMIO_LEN_4B) ? {dw, dw} : v;
  endfunction

  t_ccip_c0_ReqMmioHdr req_hdr;
  logic [14:0]         req_qw;
  logic                wr_en, wr_scratch, wr_ctrl, ctrl_clr;
  logic [63:0]         ctrl_next, scratch_q, ctrl_q, rdcnt, rd_value;
  t_mmio_rd_stage      rd_p1;
  logic                vld_p1;
  logic                unused;

  assign req_hdr    = t_ccip_c0_ReqMmioHdr'(cp2af_sRx.c0.hdr);
  assign req_qw     = req_hdr.address[15:1];
  assign wr_en      = cp2af_sRx.c0.mmioWrValid &&
                      (req_hdr.length == MMIO_LEN_4B || req_hdr.length == MMIO_LEN_8B);
  assign wr_scratch = wr_en && (req_qw == CSR_SCRATCH_QW);
  assign wr_ctrl    = wr_en && (req_qw == CSR_CTRL_QW);
  assign ctrl_next  = merge_wr(ctrl_q, cp2af_sRx.c0.data[63:0], req_hdr.length, req_hdr.address[0]);
  assign ctrl_clr   = wr_ctrl && ctrl_next[CTRL_CLR_BIT];
  assign ctrl_o     = ctrl_q;
  assign unused     = ^{cp2af_sRx.c0TxAlmFull, cp2af_sRx.c1TxAlmFull,
                        cp2af_sRx.c0.data[511:64], req_hdr.rsvd};

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q        <= '0;
      ctrl_q           <= '0;
      ctrl_clr_pulse_o <= 1'b0;
    end else begin
      if (wr_scratch)
        scratch_q <= merge_wr(scratch_q, cp2af_sRx.c0.data[63:0], req_hdr.length, req_hdr.address[0]);
      if (wr_ctrl)
        ctrl_q <= ctrl_next & ~CTRL_W1_MASK;
      ctrl_clr_pulse_o <= ctrl_clr;
    end
  end

  ccip_event_counter64 u_rdcnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cp2af_sRx.c0.rspValid),
    .clr   (ctrl_clr),
    .count (rdcnt)
  );

`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
  logic [63:0] err_q;
  logic        req_mapped, req_ro, err_hit, err_clr;

  always_comb begin
    req_mapped = 1'b1;
    req_ro     = 1'b1;
    case (req_qw)
      CSR_SCRATCH_QW, CSR_CTRL_QW: req_ro = 1'b0;
      CSR_DFH_QW, CSR_ID_L_QW, CSR_ID_H_QW, CSR_STATUS_QW, CSR_RDCNT_QW, CSR_ERR_QW: req_ro = 1'b1;
      default: begin
        req_mapped = 1'b0;
        req_ro     = 1'b0;
      end
    endcase
  end

  assign err_hit = ((cp2af_sRx.c0.mmioRdValid || cp2af_sRx.c0.mmioWrValid) && !req_mapped) ||
                   (cp2af_sRx.c0.mmioWrValid && req_ro);
  assign err_clr = wr_ctrl && ctrl_next[CTRL_ERR_CLR_BIT];

  // Only the first offender is recorded until software clears the flag
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (err_clr) begin
      err_q <= '0;
    end else if (err_hit && !err_q[63]) begin
      err_q <= {1'b1, 47'd0, req_hdr.address};
    end
  end
`endif

  // Stage p1: capture read request
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= cp2af_sRx.c0.mmioRdValid;
    rd_p1 <= '{tid: req_hdr.tid, qw: req_qw, len: req_hdr.length, dw_sel: req_hdr.address[0]};
  end

  always_comb begin
    rd_value = '0;
    case (rd_p1.qw)
      CSR_DFH_QW:     rd_value = DFH_VALUE;
      CSR_ID_L_QW:    rd_value = AFU_ID_L;
      CSR_ID_H_QW:    rd_value = AFU_ID_H;
      CSR_SCRATCH_QW: rd_value = scratch_q;
      CSR_CTRL_QW:    rd_value = ctrl_q;
      CSR_STATUS_QW:  rd_value = status_i;
      CSR_RDCNT_QW:   rd_value = rdcnt;
`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
      CSR_ERR_QW:     rd_value = err_q;
`endif
      default:        rd_value = '0;
    endcase
  end

  // Stage p2: drive completion
  always_ff @(posedge clk) begin
    if (reset) begin
      af2cp_c2Tx <= '0;
    end else begin
      af2cp_c2Tx.mmioRdValid <= vld_p1;
      af2cp_c2Tx.hdr.tid     <= rd_p1.tid;
      af2cp_c2Tx.data        <= fmt_rd(rd_value, rd_p1.len, rd_p1.dw_sel);
    end
  end

endmodule

// File: tb/tb_ccip_mmio_csr_resp.sv
// Randomized bench for ccip_mmio_csr_resp against a CSR-map reference model.
module tb_ccip_mmio_csr_resp;
  import ccip_mmio_csr_pkg::*;

  localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;
  localparam logic [63:0] ID_L = 64'h1111_2222_3333_4444;
  localparam logic [63:0] ID_H = 64'h5555_6666_7777_8888;
  localparam logic [1:0]  LEN4 = 2'b00, LEN8 = 2'b01, LEN64 = 2'b10;
`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
  localparam logic [63:0] W1_MASK = 64'h3;
`else
  localparam logic [63:0] W1_MASK = 64'h1;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  t_if_ccip_Rx    rx = '0;
  t_if_ccip_c2_Tx c2;
  logic [63:0]    ctrl_o;
  logic           pulse;
  logic [63:0]    status = 64'h0;

  always #5 clk = ~clk;

  ccip_mmio_csr_resp #(.DFH_VALUE(DFH), .AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (
    .clk              (clk),
    .reset            (reset),
    .cp2af_sRx        (rx),
    .af2cp_c2Tx       (c2),
    .ctrl_o           (ctrl_o),
    .ctrl_clr_pulse_o (pulse),
    .status_i         (status)
  );

  typedef struct {
    int          cyc;
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  rsp_t        exp_q[$], obs_q[$];
  int          exp_pulse_q[$], obs_pulse_q[$];
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] m_scratch, m_ctrl, m_rdcnt, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (c2.mmioRdValid === 1'b1) obs_q.push_back('{cyc, c2.hdr.tid, c2.data});
    if (pulse === 1'b1) obs_pulse_q.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] dw_update(input logic [63:0] old, input logic [63:0] w,
                                            input logic [1:0] len, input logic hi);
    if (len == LEN8) return w;
    return hi ? {w[31:0], old[31:0]} : {old[63:32], w[31:0]};
  endfunction

  function automatic logic [63:0] csr_value(input int b);
    case (b)
      'h00: return DFH;
      'h08: return ID_L;
      'h10: return ID_H;
      'h20: return m_scratch;
      'h28: return m_ctrl;
      'h30: return status;
      'h38: return m_rdcnt;
`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
      'h40: return m_err;
`endif
      default: return 64'h0;
    endcase
  endfunction

  function automatic bit is_mapped(input int b);
`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
    return b inside {'h00, 'h08, 'h10, 'h20, 'h28, 'h30, 'h38, 'h40};
`else
    return b inside {'h00, 'h08, 'h10, 'h20, 'h28, 'h30, 'h38};
`endif
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    rx = '0;
    m_scratch = '0; m_ctrl = '0; m_rdcnt = '0; m_err = '0;
    exp_q.delete();
    exp_pulse_q.delete();
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request cycle: drive the bus and advance the reference model by the same cycle.
  task automatic drive(input bit rd, input bit wr, input logic [15:0] addr, input logic [1:0] len,
                       input logic [8:0] tid, input logic [63:0] wdata, input bit rsp);
    t_ccip_c0_ReqMmioHdr h;
    int                  b;
    bit                  clr;
    logic [63:0]         nv, v;
    h.address = addr; h.length = t_ccip_mmioLen'(len); h.rsvd = 1'b0; h.tid = tid;
    rx = '0;
    rx.c0.hdr = h;
    rx.c0.data = {{448{1'b1}}, wdata};
    rx.c0.mmioRdValid = rd;
    rx.c0.mmioWrValid = wr;
    rx.c0.rspValid = rsp;
    b = (int'(addr) * 4) & ~7;
    clr = 1'b0;
    if (wr && (len == LEN4 || len == LEN8)) begin
      if (b == 'h20) m_scratch = dw_update(m_scratch, wdata, len, addr[0]);
      if (b == 'h28) begin
        nv = dw_update(m_ctrl, wdata, len, addr[0]);
        if (nv[0]) begin
          clr = 1'b1;
          exp_pulse_q.push_back(cyc + 1);
        end
`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
        if (nv[1]) m_err = '0;
`endif
        m_ctrl = nv & ~W1_MASK;
      end
    end
`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
    if ((((rd || wr) && !is_mapped(b)) || (wr && is_mapped(b) && b != 'h20 && b != 'h28)) && !m_err[63])
      m_err = {1'b1, 47'd0, addr};
`endif
    m_rdcnt = clr ? {63'd0, rsp} : m_rdcnt + (rsp ? 64'd1 : 64'd0);
    if (rd) begin
      v = csr_value(b);
      if (len == LEN4) v = addr[0] ? {v[63:32], v[63:32]} : {v[31:0], v[31:0]};
      exp_q.push_back('{cyc + 2, tid, v});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(3);
    obs_q.delete(); obs_pulse_q.delete();
    n_cmp++;
    if (c2 !== '0) begin
      n_bad++; $display("FAIL reset_c2: got valid=%b tid=%h data=%h, want all zero", c2.mmioRdValid, c2.hdr.tid, c2.data);
    end
    n_cmp++;
    if (ctrl_o !== 64'h0 || pulse !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got ctrl=%h pulse=%b, want 0/0", ctrl_o, pulse);
    end
    drive(1, 0, CSR_SCRATCH_DW, LEN8, 9'h011, 64'h0, 0);
    drive(1, 0, CSR_CTRL_DW,    LEN8, 9'h012, 64'h0, 0);
    drive(1, 0, CSR_RDCNT_DW,   LEN8, 9'h013, 64'h0, 0);
    idle(4);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL reset_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].tid !== exp_q[i].tid || obs_q[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL reset_rsp%0d: got cyc=%0d tid=%h data=%h, want cyc=%0d tid=%h data=%h", i,
                          obs_q[i].cyc, obs_q[i].tid, obs_q[i].data, exp_q[i].cyc, exp_q[i].tid, exp_q[i].data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_id_reads();
    while (cyc < 10) idle(1);
    drive(1, 0, CSR_DFH_DW,  LEN8,  9'h1A5, 64'h0, 0);
    drive(1, 0, CSR_ID_L_DW, LEN8,  9'h0A0, 64'h0, 0);
    drive(1, 0, CSR_ID_H_DW, LEN64, 9'h0A1, 64'h0, 0);
    drive(1, 0, 16'h0005,    LEN4,  9'h0A2, 64'h0, 0);
    idle(4);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL id_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].tid !== exp_q[i].tid || obs_q[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL id_rsp%0d: got cyc=%0d tid=%h data=%h, want cyc=%0d tid=%h data=%h", i,
                          obs_q[i].cyc, obs_q[i].tid, obs_q[i].data, exp_q[i].cyc, exp_q[i].tid, exp_q[i].data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_scratch();
    drive(0, 1, CSR_SCRATCH_DW,     LEN8, 9'h0, 64'hDEAD_BEEF_0123_4567, 0);
    drive(0, 1, CSR_SCRATCH_DW + 1, LEN4, 9'h0, 64'h0000_0000_CAFE_F00D, 0);
    drive(1, 0, CSR_SCRATCH_DW,     LEN8, 9'h021, 64'h0, 0);
    drive(1, 0, CSR_SCRATCH_DW,     LEN4, 9'h022, 64'h0, 0);
    drive(0, 1, CSR_SCRATCH_DW,     LEN64, 9'h0, 64'h1111_1111_1111_1111, 0);
    drive(0, 1, CSR_DFH_DW,         LEN8, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    drive(1, 0, CSR_SCRATCH_DW + 1, LEN4, 9'h023, 64'h0, 0);
    drive(1, 0, CSR_DFH_DW,         LEN8, 9'h024, 64'h0, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, CSR_SCRATCH_DW + 16'($urandom_range(0, 1)), $urandom_range(0, 1) ? LEN8 : LEN4,
            9'h0, {$urandom, $urandom}, 0);
      drive(1, 0, CSR_SCRATCH_DW + 16'($urandom_range(0, 1)), $urandom_range(0, 1) ? LEN8 : LEN4,
            9'($urandom), 64'h0, 0);
    end
    idle(4);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL scratch_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].tid !== exp_q[i].tid || obs_q[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL scratch_rsp%0d: got cyc=%0d tid=%h data=%h, want cyc=%0d tid=%h data=%h", i,
                          obs_q[i].cyc, obs_q[i].tid, obs_q[i].data, exp_q[i].cyc, exp_q[i].tid, exp_q[i].data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] dws[8];
    logic [15:0] pool[18];
    logic [15:0] a;
    int          op;
    dws  = '{16'h0000, 16'h0002, 16'h0004, 16'h0008, 16'h000A, 16'h000C, 16'h000E, 16'h0040};
    pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0005, 16'h0008, 16'h0009, 16'h000A, 16'h000B,
             16'h000C, 16'h000D, 16'h000E, 16'h000F, 16'h0010, 16'h0011, 16'h0018, 16'h0040, 16'h4008};
    status = {$urandom, $urandom};
    obs_pulse_q.delete(); exp_pulse_q.delete();
    for (int i = 0; i < 8; i++) drive(1, 0, dws[i], (i % 3 == 1) ? LEN4 : LEN8, 9'(i), 64'h0, i[0]);
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : pool[$urandom_range(0, 17)];
      if (op < 5)      drive(1, 0, a, 2'($urandom_range(0, 2)), 9'($urandom), 64'h0, $urandom_range(0, 2) == 0);
      else if (op < 8) drive(0, 1, $urandom_range(0, 1) ? CSR_SCRATCH_DW + 16'($urandom_range(0, 1))
                                                        : CSR_CTRL_DW + 16'($urandom_range(0, 1)),
                             2'($urandom_range(0, 2)), 9'h0, {$urandom, $urandom}, $urandom_range(0, 2) == 0);
      else if (op < 9) drive(0, 1, a, 2'($urandom_range(0, 2)), 9'h0, {$urandom, $urandom}, 0);
      else             drive(0, 0, 16'h0, LEN8, 9'h0, 64'h0, 1);
    end
    idle(4);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL b2b_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].tid !== exp_q[i].tid || obs_q[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL b2b_rsp%0d: got cyc=%0d tid=%h data=%h, want cyc=%0d tid=%h data=%h", i,
                          obs_q[i].cyc, obs_q[i].tid, obs_q[i].data, exp_q[i].cyc, exp_q[i].tid, exp_q[i].data);
      end
    end
    n_cmp++;
    if (obs_pulse_q != exp_pulse_q) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d pulse cycles, want %0d", obs_pulse_q.size(), exp_pulse_q.size());
    end
    exp_q.delete(); obs_q.delete(); obs_pulse_q.delete(); exp_pulse_q.delete();
  endtask

  task automatic test_rdcnt_clear();
    obs_pulse_q.delete(); exp_pulse_q.delete();
    repeat (5) drive(0, 0, 16'h0, LEN8, 9'h0, 64'h0, 1);
    drive(1, 0, CSR_RDCNT_DW, LEN8, 9'h031, 64'h0, 0);
    drive(0, 1, CSR_CTRL_DW,  LEN8, 9'h0, 64'hA5A5_0000_0000_F0F1, 1);
    drive(1, 0, CSR_RDCNT_DW, LEN8, 9'h032, 64'h0, 0);
    drive(1, 0, CSR_CTRL_DW,  LEN8, 9'h033, 64'h0, 0);
    idle(4);
    n_cmp++;
    if (ctrl_o !== m_ctrl || ctrl_o[0] !== 1'b0) begin
      n_bad++; $display("FAIL ctrl_o: got %h, want %h", ctrl_o, m_ctrl);
    end
    n_cmp++;
    if (obs_pulse_q.size() != 1 || obs_pulse_q != exp_pulse_q) begin
      n_bad++; $display("FAIL clr_pulse: got %0d pulse cycles (first %0d), want 1 at cycle %0d",
                        obs_pulse_q.size(), obs_pulse_q.size() ? obs_pulse_q[0] : -1,
                        exp_pulse_q.size() ? exp_pulse_q[0] : -1);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL rdcnt_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].tid !== exp_q[i].tid || obs_q[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL rdcnt_rsp%0d: got cyc=%0d tid=%h data=%h, want cyc=%0d tid=%h data=%h", i,
                          obs_q[i].cyc, obs_q[i].tid, obs_q[i].data, exp_q[i].cyc, exp_q[i].tid, exp_q[i].data);
      end
    end
    exp_q.delete(); obs_q.delete(); obs_pulse_q.delete(); exp_pulse_q.delete();
  endtask

  task automatic test_reset_midflight();
    drive(0, 1, CSR_SCRATCH_DW, LEN8, 9'h0, {$urandom, $urandom} | 64'h1, 0);
    obs_q.delete();
    drive(1, 0, CSR_SCRATCH_DW, LEN8, 9'h055, 64'h0, 0);
    do_reset(1);
    n_cmp++;
    if (c2.mmioRdValid !== 1'b0) begin
      n_bad++; $display("FAIL midreset_valid: got mmioRdValid=%b after reset, want 0", c2.mmioRdValid);
    end
    idle(4);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++; $display("FAIL midreset_dropped: got %0d responses (tid %h), want 0", obs_q.size(), obs_q[0].tid);
    end
    obs_q.delete();
    drive(1, 0, CSR_SCRATCH_DW, LEN8, 9'h056, 64'h0, 0);
    idle(4);
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_bad++; $display("FAIL midreset_count: got %0d responses, want 1", obs_q.size());
    end else if (obs_q[0].cyc !== exp_q[0].cyc || obs_q[0].tid !== exp_q[0].tid || obs_q[0].data !== 64'h0) begin
      n_bad++; $display("FAIL midreset_scratch: got cyc=%0d tid=%h data=%h, want cyc=%0d tid=%h data=0",
                        obs_q[0].cyc, obs_q[0].tid, obs_q[0].data, exp_q[0].cyc, exp_q[0].tid);
    end
    exp_q.delete(); obs_q.delete(); obs_pulse_q.delete();
  endtask

`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
  task automatic test_err_log();
    do_reset(2);
    obs_q.delete(); obs_pulse_q.delete();
    drive(0, 1, CSR_ID_L_DW, LEN8, 9'h0,   64'h1234, 0);
    drive(1, 0, 16'h0080,    LEN8, 9'h061, 64'h0, 0);
    drive(1, 0, CSR_ERR_DW,  LEN8, 9'h062, 64'h0, 0);
    drive(0, 1, CSR_CTRL_DW, LEN8, 9'h0,   64'h2, 0);
    drive(1, 0, CSR_ERR_DW,  LEN8, 9'h063, 64'h0, 0);
    drive(1, 0, CSR_CTRL_DW, LEN8, 9'h064, 64'h0, 0);
    idle(4);
    n_cmp++;
    if (obs_q.size() < 2 || obs_q[1].data !== 64'h8000_0000_0000_0002) begin
      n_bad++; $display("FAIL err_capture: got %h, want 8000000000000002", obs_q.size() > 1 ? obs_q[1].data : 64'h0);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL err_count: got %0d responses, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].tid !== exp_q[i].tid || obs_q[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL err_rsp%0d: got cyc=%0d tid=%h data=%h, want cyc=%0d tid=%h data=%h", i,
                          obs_q[i].cyc, obs_q[i].tid, obs_q[i].data, exp_q[i].cyc, exp_q[i].tid, exp_q[i].data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_id_reads();
    test_scratch();
    test_back_to_back();
    test_rdcnt_clear();
    test_reset_midflight();
`ifdef CCIP_MMIO_CSR_ERR_LOG_EN
    test_err_log();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccip_mmio_csr_resp.md
Name: ccip_mmio_csr_resp

Overview:
- Host-facing CSR endpoint for an AFU.
- Consumes MMIO requests arriving on CCI-P Rx channel 0 and returns read completions on Tx channel 2.
- Holds a small CSR file: device header, AFU ID, scratch, control, status, read-response counter.
- Sits directly downstream of the CCI-P Rx struct and directly upstream of the c2 Tx mux.

Parameters:
- DFH_VALUE, 64'h1000_0000_0000_0000, read-only value at byte offset 0x00.
- AFU_ID_L, 64'h0, read-only value at byte offset 0x08.
- AFU_ID_H, 64'h0, read-only value at byte offset 0x10.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- cp2af_sRx  in  t_if_ccip_Rx  CCI-P Rx bundle; only c0 is used.
- af2cp_c2Tx  out  t_if_ccip_c2_Tx  MMIO read response.
- ctrl_o  out  64  current CTRL register value; bit0 always reads 0.
- ctrl_clr_pulse_o  out  1  one-cycle pulse when CTRL bit0 is written with 1.
- status_i  in  64  live value returned for STATUS reads.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: af2cp_c2Tx all zero (mmioRdValid=0); SCRATCH=0; CTRL=0; RDCNT=0; ctrl_clr_pulse_o=0.
- Request header: when mmioRdValid or mmioWrValid is set, c0.hdr is cast to t_ccip_c0_ReqMmioHdr. The address is DW (4B) aligned, so byte offset = address<<2.
- CSR map (byte offset, access):
  - 0x00 DFH, RO
  - 0x08 ID_L, RO
  - 0x10 ID_H, RO
  - 0x20 SCRATCH, RW
  - 0x28 CTRL, RW; bit0 is W1 pulse
  - 0x30 STATUS, RO
  - 0x38 RDCNT, RO
- Decode uses all 16 address bits. The DW-within-QW bit is address[0].
- Write, length 8B: full 64b update at the QW; address[0] is ignored.
- Write, length 4B: updates only DW address[0] with data[31:0].
- Write, length 64B: ignored.
- Writes to RO or unmapped offsets: ignored.
- Write commit: the register updates on the clock edge ending the request cycle.
- Read pipeline: 2 stages; a request in cycle N gives mmioRdValid in N+2.
  - Stage 1 registers tid, QW index, length, DW select.
  - Stage 2 muxes the register value into data and drives mmioRdValid=1 with hdr.tid = request tid.
- Read throughput: one read per cycle, no stalls; c2 has no backpressure.
- Read-after-write: a read in cycle N+1 after a write in cycle N returns the new value.
- Read data by length:
  - 8B: full QW.
  - 4B: selected DW replicated into both halves.
  - 64B: treated as 8B.
  - Unmapped offset: 64'h0.
- RDCNT: 64b counter, +1 on every cycle with cp2af_sRx.c0.rspValid=1. Wraps 2^64-1 -> 0.
- CTRL bit0 write of 1: ctrl_clr_pulse_o=1 in the next cycle and RDCNT clears.
  - If clear and increment land in the same cycle, RDCNT=1.
- mmioRdValid and mmioWrValid are never both set (CCI-P rule). No arbitration is needed.
- Reset mid-operation: in-flight reads are dropped. No response is emitted after reset, and mmioRdValid=0 on the cycle after reset is sampled.
- Timeout: the fixed latency of 2 is far below the 512-cycle MMIO read timeout.

Optional Feature:
- Macro: CCIP_MMIO_CSR_ERR_LOG_EN.
- When defined: adds ERR CSR at 0x40, RO.
  - bit63: sticky flag; set on the first access to an unmapped offset or a write to an RO offset.
  - bits[15:0]: DW address of that first offending access; held until CTRL bit1 is written with 1.
  - CTRL bit1 behaves as a W1 pulse and reads 0.
- When undefined: no ERR logic; 0x40 is unmapped and reads 0; CTRL bit1 is a plain RW bit.

Decomposition:
- ccip_mmio_csr_pkg holds:
  - CSR byte offsets and DW-index constants.
  - CTRL bit positions.
  - t_mmio_rd_stage struct (tid, qw index, length, dw select).
- One natural sub-module: ccip_event_counter64, a 64b counter with inc and clr inputs where clr+inc gives 1.

Test Plan:
- Read DFH, 8B, tid=0x1A5 at cycle 10 -> mmioRdValid at cycle 12, tid=0x1A5, data=DFH_VALUE.
- Write SCRATCH 8B 64'hDEAD_BEEF_0123_4567, then 4B write at DW 0x9 of 32'hCAFEF00D, then 8B read -> 64'hCAFEF00D_0123_4567. 4B read at DW 0x8 -> 64'h01234567_01234567.
- 8 back-to-back reads, tids 0..7, to mixed offsets -> 8 consecutive mmioRdValid cycles, tids in order, correct data; unmapped 0x100 returns 0.
- 5 rspValid pulses, then CTRL write 1 coincident with one rspValid -> RDCNT=1 afterwards; ctrl_clr_pulse_o high exactly 1 cycle; ctrl_o bit0 reads 0.
- Read issued, then reset asserted the next cycle -> no mmioRdValid ever produced for it; SCRATCH reads 0 after reset.
- With CCIP_MMIO_CSR_ERR_LOG_EN: write to ID_L (DW 0x2), then read 0x200 -> ERR = {1'b1, ..., 16'h0002}. CTRL bit1 write clears it to 0.
